// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - N-layer priority compositor with frame-synchronous masks; optional colour-key via LAYER_COMPOSITOR_TKEY_EN
module layer_compositor #(
    parameter int               NLAYERS   = 4,
    parameter int               CHB       = 1,
    parameter int               RGBW      = 18,
    parameter bit               VS_POL    = 1'b0,
    parameter int               BLINK_BIT = 4,
    parameter logic [3*CHB-1:0] TKEY      = '0
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic                     ihs,
    input  logic                     ivs,
    input  logic                     ipix_active,
    input  logic [NLAYERS-1:0]       ilayer_en,
    input  logic [NLAYERS*3*CHB-1:0] ilayer_data,
    input  logic [3*CHB-1:0]         ibg_color,
    input  logic                     imask_wr,
    input  logic [NLAYERS-1:0]       imask_vis,
    input  logic [NLAYERS-1:0]       imask_blink,
    output logic                     ohs,
    output logic                     ovs,
    output logic                     ode,
    output logic [3*CHB-1:0]         ocolor,
    output logic [RGBW-1:0]          odata,
    output logic [7:0]               oframe_cnt
);

    localparam int CW = 3 * CHB;
    localparam int OW = RGBW / 3;

`ifdef LAYER_COMPOSITOR_TKEY_EN
    localparam bit TKEY_EN = 1'b1;
`else
    localparam bit TKEY_EN = 1'b0;
`endif

    logic                  s1_hs, s1_vs, s1_vs_prev, s1_act;
    logic [NLAYERS-1:0]    s1_en;
    logic [NLAYERS*CW-1:0] s1_data;
    logic [CW-1:0]         s1_bg;

    logic [NLAYERS-1:0]    pend_vis, pend_blink, act_vis, act_blink;
    logic                  frame_edge;

    logic [NLAYERS-1:0]    qual;
    logic [CW-1:0]         sel;

    logic                  s2_hs, s2_vs, s2_act;
    logic [CW-1:0]         s2_color;
    logic [RGBW-1:0]       rgb;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            s1_hs      <= ~VS_POL;
            s1_vs      <= ~VS_POL;
            s1_vs_prev <= ~VS_POL;
            s1_act     <= 1'b0;
            s1_en      <= '0;
            s1_data    <= '0;
            s1_bg      <= '0;
        end else begin
            s1_hs      <= ihs;
            s1_vs      <= ivs;
            s1_vs_prev <= s1_vs;
            s1_act     <= ipix_active;
            s1_en      <= ilayer_en;
            s1_data    <= ilayer_data;
            s1_bg      <= ibg_color;
        end
    end

    assign frame_edge = (s1_vs == VS_POL) && (s1_vs_prev != VS_POL);

    // Active masks copy the pending value before this clock's write lands,
    // so a write coincident with an edge waits for the following frame.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            pend_vis   <= '1;
            pend_blink <= '0;
            act_vis    <= '1;
            act_blink  <= '0;
            oframe_cnt <= 8'd0;
        end else begin
            if (frame_edge) begin
                act_vis    <= pend_vis;
                act_blink  <= pend_blink;
                oframe_cnt <= oframe_cnt + 8'd1;
            end
            if (imask_wr) begin
                pend_vis   <= imask_vis;
                pend_blink <= imask_blink;
            end
        end
    end

    always_comb begin
        qual = '0;
        for (int k = 0; k < NLAYERS; k++) begin
            qual[k] = s1_en[k] && act_vis[k]
                      && !(act_blink[k] && oframe_cnt[BLINK_BIT])
                      && !(TKEY_EN && (s1_data[k*CW +: CW] == TKEY));
        end
    end

    // Scan from lowest priority upward so the lowest qualifying index wins.
    always_comb begin
        sel = s1_bg;
        for (int k = NLAYERS - 1; k >= 0; k--) begin
            if (qual[k]) begin
                sel = s1_data[k*CW +: CW];
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            s2_hs    <= ~VS_POL;
            s2_vs    <= ~VS_POL;
            s2_act   <= 1'b0;
            s2_color <= '0;
        end else begin
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
            s2_act   <= s1_act;
            s2_color <= sel;
        end
    end

    always_comb begin
        rgb = '0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < OW; i++) begin
                rgb[c*OW + OW - 1 - i] = s2_color[c*CHB + CHB - 1 - (i % CHB)];
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            ohs    <= ~VS_POL;
            ovs    <= ~VS_POL;
            ode    <= 1'b0;
            ocolor <= '0;
            odata  <= '0;
        end else begin
            ohs    <= s2_hs;
            ovs    <= s2_vs;
            ode    <= s2_act;
            ocolor <= s2_color;
            odata  <= s2_act ? rgb : '0;
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - scoreboard bench for layer_compositor (NLAYERS=4, CHB=1, RGBW=18, VS_POL=0)
module tb_layer_compositor;

    logic        clk;
    logic        rst_n;
    logic        hs, vs, act, wr;
    logic [3:0]  en, vis, blink;
    logic [11:0] data;
    logic [2:0]  bg;
    logic        ohs, ovs, ode;
    logic [2:0]  ocolor;
    logic [17:0] odata;
    logic [7:0]  oframe_cnt;

    layer_compositor #(
        .NLAYERS(4), .CHB(1), .RGBW(18), .VS_POL(1'b0), .BLINK_BIT(4), .TKEY(3'b000)
    ) dut (
        .iclk(clk), .irst_n(rst_n), .ihs(hs), .ivs(vs), .ipix_active(act),
        .ilayer_en(en), .ilayer_data(data), .ibg_color(bg),
        .imask_wr(wr), .imask_vis(vis), .imask_blink(blink),
        .ohs(ohs), .ovs(ovs), .ode(ode), .ocolor(ocolor), .odata(odata),
        .oframe_cnt(oframe_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [2:0]  color;
        logic [17:0] data;
    } out_t;

    typedef struct {
        logic [3:0]  en;
        logic [11:0] data;
        logic [2:0]  bg;
        logic        act;
        logic [2:0]  exp_color;
    } vec_t;

    localparam out_t IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, color: 3'b000, data: 18'h0};

    out_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         nstep = 0;

    logic [3:0] m_pend_vis, m_pend_blink, m_act_vis, m_act_blink;
    logic [7:0] m_fcnt;
    logic       h1, h2;

    function automatic logic [11:0] lay(input logic [2:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [17:0] expand(input logic [2:0] c);
        return {{6{c[2]}}, {6{c[1]}}, {6{c[0]}}};
    endfunction

    function automatic logic [2:0] model_sel(input logic [3:0] e, input logic [11:0] d, input logic [2:0] b);
        logic [2:0] r;
        logic [2:0] px;
        r = b;
        for (int k = 0; k < 4; k++) begin
            px = d[k*3 +: 3];
            if (e[k] && m_act_vis[k] && !(m_act_blink[k] && m_fcnt[4])
`ifdef LAYER_COMPOSITOR_TKEY_EN
                && (px != 3'b000)
`endif
                ) begin
                r = px;
                break;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_pend_vis   = 4'hF;
        m_act_vis    = 4'hF;
        m_pend_blink = 4'h0;
        m_act_blink  = 4'h0;
        m_fcnt       = 8'd0;
        h1 = 1'b1;
        h2 = 1'b1;
    endtask

    task automatic check_outputs();
        out_t got, exp;
        got = '{hs: ohs, vs: ovs, de: ode, color: ocolor, data: odata};
        exp = (sb.size() >= 3) ? sb.pop_front() : IDLE;
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL pixel step=%0d got hs=%b vs=%b de=%b color=%b data=%h want hs=%b vs=%b de=%b color=%b data=%h",
                     nstep, got.hs, got.vs, got.de, got.color, got.data,
                     exp.hs, exp.vs, exp.de, exp.color, exp.data);
        end
        total++;
        if (oframe_cnt !== m_fcnt) begin
            bad++;
            $display("FAIL frame_cnt step=%0d got=%0d want=%0d", nstep, oframe_cnt, m_fcnt);
        end
    endtask

    // Called at a falling edge: check the output due now, then drive and predict the next input.
    task automatic step(input logic s_hs, s_vs, s_act, input logic [3:0] s_en, input logic [11:0] s_data,
                        input logic [2:0] s_bg, input logic s_wr, input logic [3:0] s_vis, s_blink,
                        input bit use_tbl, input logic [2:0] tbl_color);
        logic [2:0] c;
        check_outputs();
        hs = s_hs; vs = s_vs; act = s_act; en = s_en; data = s_data; bg = s_bg;
        wr = s_wr; vis = s_vis; blink = s_blink;
        if (h1 == 1'b0 && h2 == 1'b1) begin
            m_act_vis   = m_pend_vis;
            m_act_blink = m_pend_blink;
            m_fcnt      = m_fcnt + 8'd1;
        end
        if (s_wr) begin
            m_pend_vis   = s_vis;
            m_pend_blink = s_blink;
        end
        c = use_tbl ? tbl_color : model_sel(s_en, s_data, s_bg);
        sb.push_back('{hs: s_hs, vs: s_vs, de: s_act, color: c, data: s_act ? expand(c) : 18'h0});
        h2 = h1;
        h1 = s_vs;
        nstep++;
        @(negedge clk);
    endtask

    task automatic pix(input logic [3:0] s_en, input logic [11:0] s_data, input logic [2:0] s_bg, input logic s_act);
        step(1'b1, 1'b1, s_act, s_en, s_data, s_bg, 1'b0, 4'h0, 4'h0, 1'b0, 3'b000);
    endtask

    task automatic run_frame(input int len, input logic [3:0] s_en, input logic [11:0] s_data,
                             input logic [2:0] s_bg, input int wr_at, input logic [3:0] s_vis, s_blink);
        for (int i = 0; i < len; i++) begin
            step(i != 1, i != 0, i >= 2, s_en, s_data, s_bg, i == wr_at, s_vis, s_blink, 1'b0, 3'b000);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hs = 1'b1; vs = 1'b1; act = 1'b0; en = '0; data = '0; bg = '0;
        wr = 1'b0; vis = '0; blink = '0;
        model_reset();
        #2;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at step=%0d", nstep);
        $fatal(1, "watchdog");
    end

    vec_t tbl[7];

    initial begin
        tbl[0] = '{4'b1010, lay(3'b000, 3'b100, 3'b000, 3'b010), 3'b000, 1'b1, 3'b100};
        tbl[1] = '{4'b0000, 12'h000, 3'b001, 1'b1, 3'b001};
        tbl[2] = '{4'b0000, 12'h000, 3'b001, 1'b0, 3'b001};
        tbl[3] = '{4'b1111, lay(3'b011, 3'b101, 3'b110, 3'b111), 3'b010, 1'b1, 3'b011};
        tbl[4] = '{4'b1100, lay(3'b011, 3'b101, 3'b110, 3'b001), 3'b010, 1'b1, 3'b110};
        tbl[5] = '{4'b1000, lay(3'b011, 3'b101, 3'b110, 3'b001), 3'b010, 1'b1, 3'b001};
`ifdef LAYER_COMPOSITOR_TKEY_EN
        tbl[6] = '{4'b0101, lay(3'b000, 3'b110, 3'b011, 3'b111), 3'b010, 1'b1, 3'b011};
`else
        tbl[6] = '{4'b0101, lay(3'b000, 3'b110, 3'b011, 3'b111), 3'b010, 1'b1, 3'b000};
`endif

        rst_n = 1'b1;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, tbl[i].act, tbl[i].en, tbl[i].data, tbl[i].bg,
                 1'b0, 4'h0, 4'h0, 1'b1, tbl[i].exp_color);
        end

        // One-cycle hs pulse coincident with a pixel change
        for (int i = 0; i < 16; i++) begin
            step(i != 10, 1'b1, 1'b1, 4'b0001, lay((i >= 10) ? 3'b101 : 3'b010, 3'b0, 3'b0, 3'b0),
                 3'b001, 1'b0, 4'h0, 4'h0, 1'b0, 3'b000);
        end

        // Mid-frame hide of layer 1, then a write coincident with the frame edge
        run_frame(10, 4'b0010, lay(3'b000, 3'b100, 3'b000, 3'b000), 3'b001, -1, 4'h0, 4'h0);
        run_frame(10, 4'b0010, lay(3'b000, 3'b100, 3'b000, 3'b000), 3'b001, 5, 4'b1101, 4'h0);
        run_frame(10, 4'b0010, lay(3'b000, 3'b100, 3'b000, 3'b000), 3'b001, -1, 4'h0, 4'h0);
        run_frame(10, 4'b0010, lay(3'b000, 3'b100, 3'b000, 3'b000), 3'b001, 1, 4'b1111, 4'h0);
        run_frame(10, 4'b0010, lay(3'b000, 3'b100, 3'b000, 3'b000), 3'b001, -1, 4'h0, 4'h0);
        run_frame(10, 4'b0010, lay(3'b000, 3'b100, 3'b000, 3'b000), 3'b001, -1, 4'h0, 4'h0);

        // Blink on layer 0 across a full counter wrap
        run_frame(5, 4'b0001, lay(3'b111, 3'b0, 3'b0, 3'b0), 3'b001, 3, 4'b1111, 4'b0001);
        for (int f = 0; f < 270; f++) begin
            run_frame(4, 4'b0001, lay(3'b111, 3'b0, 3'b0, 3'b0), 3'b001, -1, 4'h0, 4'h0);
        end

        // Reset in the middle of a line, then randomised traffic
        for (int i = 0; i < 5; i++) pix(4'b0110, lay(3'b001, 3'b010, 3'b011, 3'b100), 3'b101, 1'b1);
        #1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0), ((i % 13) != 0), ($urandom_range(0, 3) != 0),
                 4'($urandom), 12'($urandom), 3'($urandom),
                 ($urandom_range(0, 7) == 0), 4'($urandom), 4'($urandom), 1'b0, 3'b000);
        end
        for (int i = 0; i < 4; i++) pix(4'h0, 12'h0, 3'b000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
